// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// Word/address widths, zero-register index and FSM encodings.
package rf_write_arbiter_pkg;

    localparam int WORDSIZE = 64;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_OWN0 = 2'b01,
        S_OWN1 = 2'b10
    } state_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request channel: valid/ready handshake with address and data.
interface rf_write_arbiter_if
    import rf_write_arbiter_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = WORDSIZE
);

    logic          valid;
    logic          ready;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;

    modport master (
        output valid,
        output addr,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  data,
        output ready
    );

endinterface

// File: rtl/rf_write_arbiter_picker.sv
// Combinational round-robin winner with bounded bursts.
// Kept standalone so the data-memory port arbiter can reuse it.
module rr_burst_picker #(
    parameter int MAX_BURST = 2,
    parameter int CNT_W     = 2
) (
    input  logic             valid0,
    input  logic             valid1,
    input  logic             last_grant,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             grant,
    output logic             any
);

    always_comb begin
        any   = valid0 | valid1;
        grant = 1'b0;
        unique case (1'b1)
            (valid0 && valid1):
                grant = (burst_cnt < CNT_W'(MAX_BURST)) ?
                        last_grant : ~last_grant;
            (valid1 && !valid0):
                grant = 1'b1;
            default:
                grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write port arbiter with a registered
// write stage; one accepted request per cycle, written the next cycle.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int WORDSIZE  = rf_write_arbiter_pkg::WORDSIZE,
    parameter int ADDR_W    = rf_write_arbiter_pkg::ADDR_W,
    parameter int MAX_BURST = 2
) (
    input  logic                clk,
    input  logic                rst,
    rf_write_arbiter_if.slave   req0,
    rf_write_arbiter_if.slave   req1,
    output logic                rf_write_enable,
    output logic [ADDR_W-1:0]   rf_write_addr,
    output logic [WORDSIZE-1:0] rf_write_data,
    output logic                grant_id,
    output logic                contended
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t              state;
    state_t              state_nxt;
    logic                last_grant;
    logic                last_nxt;
    logic [CNT_W-1:0]    burst_cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic                pick;
    logic                any_valid;
    logic                xfer;
    logic [ADDR_W-1:0]   sel_addr;
    logic [WORDSIZE-1:0] sel_data;

    rr_burst_picker #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_picker (
        .valid0     (req0.valid),
        .valid1     (req1.valid),
        .last_grant (last_grant),
        .burst_cnt  (burst_cnt),
        .grant      (pick),
        .any        (any_valid)
    );

    always_comb begin
        xfer       = !rst && any_valid;
        req0.ready = xfer && !pick;
        req1.ready = xfer && pick;
        sel_addr   = pick ? req1.addr : req0.addr;
        sel_data   = pick ? req1.data : req0.data;
        state_nxt  = S_IDLE;
        last_nxt   = last_grant;
        cnt_nxt    = '0;
        if (xfer) begin
            state_nxt = pick ? S_OWN1 : S_OWN0;
            if (pick == last_grant) begin
                cnt_nxt = (burst_cnt == CNT_W'(MAX_BURST)) ?
                          burst_cnt : burst_cnt + CNT_W'(1);
            end else begin
                cnt_nxt  = CNT_W'(1);
                last_nxt = pick;
            end
        end
    end

    // Writes to the hardwired zero register are accepted but never strobed.
    assign rf_write_enable = (state != S_IDLE) &&
                             (rf_write_addr != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            last_grant    <= 1'b1;
            burst_cnt     <= '0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            grant_id      <= 1'b0;
            contended     <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_nxt;
            burst_cnt  <= cnt_nxt;
            contended  <= req0.valid && req1.valid;
            if (xfer) begin
                rf_write_addr <= sel_addr;
                rf_write_data <= sel_data;
                grant_id      <= pick;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench: a reference model predicts each cycle's write,
// a monitor compares the registered write port one cycle later.
module tb_rf_write_arbiter;

    localparam int MAXB = 2;

    typedef struct {
        bit          rs;
        bit          xfer;
        logic [4:0]  addr;
        logic [63:0] data;
        bit          gid;
        bit          cont;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [63:0] rf_write_data;
    logic        grant_id;
    logic        contended;

    rf_write_arbiter_if r0 ();
    rf_write_arbiter_if r1 ();

    rf_write_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk             (clk),
        .rst             (rst),
        .req0            (r0.slave),
        .req1            (r1.slave),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .grant_id        (grant_id),
        .contended       (contended)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    exp_t        q[$];
    logic [63:0] exp_rf [32];
    logic [63:0] dut_rf [32];
    bit          acc0, acc1;
    bit          m_last;
    int          m_cnt;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: applies the arbitration rules to the visible requests.
    initial begin
        exp_t e;
        bit   w;
        m_last = 1'b1;
        m_cnt  = 0;
        forever begin
            @(negedge clk);
            e = '{rs: 0, xfer: 0, addr: 0, data: 0, gid: 0, cont: 0};
            acc0 = 0;
            acc1 = 0;
            if (rst) begin
                chk("ready0_rst", 64'(r0.ready), 64'd0);
                chk("ready1_rst", 64'(r1.ready), 64'd0);
                e.rs   = 1;
                m_last = 1'b1;
                m_cnt  = 0;
            end else begin
                e.cont = r0.valid && r1.valid;
                if (r0.valid || r1.valid) begin
                    if (r0.valid && r1.valid)
                        w = (m_cnt < MAXB) ? m_last : !m_last;
                    else
                        w = r1.valid;
                    if (w == m_last) begin
                        m_cnt = (m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1;
                    end else begin
                        m_cnt  = 1;
                        m_last = w;
                    end
                    acc0   = !w;
                    acc1   = w;
                    e.xfer = 1;
                    e.gid  = w;
                    e.addr = w ? r1.addr : r0.addr;
                    e.data = w ? r1.data : r0.data;
                    if (e.addr != 0) exp_rf[e.addr] = e.data;
                end else begin
                    m_cnt = 0;
                end
                chk("ready0", 64'(r0.ready), 64'(acc0));
                chk("ready1", 64'(r1.ready), 64'(acc1));
            end
            q.push_back(e);
        end
    end

    // Monitor: the write port registered at the last edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("wr_en", 64'(rf_write_enable),
                    64'(e.xfer && e.addr != 0));
                chk("contended", 64'(contended), 64'(e.cont));
                if (e.rs || e.xfer) begin
                    chk("wr_addr", 64'(rf_write_addr), 64'(e.addr));
                    chk("wr_data", rf_write_data, e.data);
                    chk("grant_id", 64'(grant_id), 64'(e.gid));
                end
                if (rf_write_enable) dut_rf[rf_write_addr] = rf_write_data;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (acc0) r0.valid = 1'b0;
        if (acc1) r1.valid = 1'b0;
    endtask

    task automatic req(int i, logic [4:0] a, logic [63:0] d);
        if (i == 0) begin
            r0.valid = 1'b1; r0.addr = a; r0.data = d;
        end else begin
            r1.valid = 1'b1; r1.addr = a; r1.data = d;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((r0.valid || r1.valid) && n < 30) begin
            step();
            n++;
        end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL drain: requests still pending after %0d cycles", n);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) begin
            exp_rf[i] = '0;
            dut_rf[i] = '0;
        end
        r0.valid = 0; r0.addr = 0; r0.data = 0;
        r1.valid = 0; r1.addr = 0; r1.data = 0;
        rst = 1'b1;
        req(0, 5'd1, 64'h11);
        req(1, 5'd2, 64'h22);
        step();
        step();
        rst = 1'b0;
        drain();
        step();

        req(1, 5'd7, 64'hDEAD);
        drain();
        step();

        repeat (12) begin
            if (!r0.valid) req(0, 5'(8 + $urandom_range(7)), rnd64());
            if (!r1.valid) req(1, 5'(16 + $urandom_range(7)), rnd64());
            step();
        end
        drain();
        step();

        req(0, 5'd0, 64'd5);
        drain();
        req(0, 5'd10, 64'hA0);
        req(1, 5'd11, 64'hB1);
        drain();
        step();

        req(1, 5'd9, 64'h99);
        drain();
        step();
        req(0, 5'd3, 64'd1);
        req(1, 5'd3, 64'd2);
        drain();
        step();

        req(0, 5'd4, 64'h44);
        rst = 1'b1;
        step();
        rst = 1'b0;
        req(1, 5'd5, 64'h55);
        drain();
        step();

        repeat (400) begin
            rst = ($urandom_range(99) < 3);
            if (!r0.valid && $urandom_range(99) < 60)
                req(0, 5'($urandom_range(7)), rnd64());
            if (!r1.valid && $urandom_range(99) < 60)
                req(1, 5'($urandom_range(7)), rnd64());
            step();
        end
        rst = 1'b0;
        drain();
        repeat (3) step();

        for (int i = 1; i < 32; i++)
            chk($sformatf("rf[%0d]", i), dut_rf[i], exp_rf[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
